fifo_param: RTL and testbench

Parametrised synchronous FIFO, next generation of the team's 8-bit FIFO. Data width and depth are configurable. It adds programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode. It sits between a producer and consumer in the same clock domain and is driven by the existing layered testbench through a widened version of the FIFO interface.

---
 rtl/fifo_param_if.sv | 31 +++
 rtl/fifo_param.sv | 90 +++++++++
 tb/tb_fifo_param.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/fifo_param_if.sv
// rtl/fifo_param_if.sv - producer/consumer handshake and status bundle for fifo_param
interface fifo_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] buf_in;
    logic [WIDTH-1:0] buf_out;
    logic             buf_empty;
    logic             buf_full;
    logic             buf_almost_full;
    logic             buf_almost_empty;
    logic [CW-1:0]    fifo_counter;
    logic             overflow;
    logic             underflow;

    modport master (
        output wr_en, rd_en, buf_in,
        input  buf_out, buf_empty, buf_full, buf_almost_full, buf_almost_empty,
               fifo_counter, overflow, underflow
    );

    modport slave (
        input  wr_en, rd_en, buf_in,
        output buf_out, buf_empty, buf_full, buf_almost_full, buf_almost_empty,
               fifo_counter, overflow, underflow
    );
endinterface

// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - parametrised synchronous FIFO with thresholds, sticky errors and FWFT mode
// The interface instance must carry the same WIDTH and DEPTH as this module.
module fifo_param #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic        clk,
    input  logic        rst,
    fifo_param_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q, wp_d;
    logic [AW-1:0]    rp_q, rp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             empty, full, rd_acc, wr_acc;

    assign empty  = (cnt_q == '0);
    assign full   = (cnt_q == CW'(DEPTH));
    assign rd_acc = bus.rd_en && !empty;
    // A write while full is legal when a read frees the slot in the same cycle.
    assign wr_acc = bus.wr_en && (!full || bus.rd_en);

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (wr_acc) wp_d = wp_q + 1'b1;
        if (rd_acc) rp_d = rp_q + 1'b1;
        cnt_d = cnt_q + {{(CW-1){1'b0}}, wr_acc} - {{(CW-1){1'b0}}, rd_acc};
        if (bus.wr_en && !wr_acc) ovf_d = 1'b1;
        if (bus.rd_en && !rd_acc) unf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_acc) mem_q[wp_q] <= bus.buf_in;
    end

    assign bus.fifo_counter     = cnt_q;
    assign bus.buf_empty        = empty;
    assign bus.buf_full         = full;
    assign bus.buf_almost_full  = (cnt_q >= CW'(AF_THRESH));
    assign bus.buf_almost_empty = (cnt_q <= CW'(AE_THRESH));
    assign bus.overflow         = ovf_q;
    assign bus.underflow        = unf_q;

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.buf_out = empty ? '0 : mem_q[rp_q];
        end else begin : g_reg
            logic [WIDTH-1:0] dout_q, dout_d;

            always_comb begin
                dout_d = dout_q;
                if (rd_acc) dout_d = mem_q[rp_q];
            end

            always_ff @(posedge clk) begin
                if (rst) dout_q <= '0;
                else     dout_q <= dout_d;
            end

            assign bus.buf_out = dout_q;
        end
    endgenerate
endmodule

// File: tb/tb_fifo_param.sv
// tb/tb_fifo_param.sv - directed scoreboard bench for fifo_param (registered and FWFT variants)
module tb_fifo_param;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    fifo_param_if #(.WIDTH(8), .DEPTH(16)) bus0 ();
    fifo_param_if #(.WIDTH(8), .DEPTH(8))  bus1 ();

    fifo_param #(.WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave)
    );
    fifo_param #(.WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave)
    );

    always #5 clk = ~clk;

    logic [7:0] sb0[$];
    logic [7:0] sb1[$];
    int         m0, m1, next_seq;
    logic       ovf0, unf0, ovf1, unf1;
    logic [7:0] last0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk0_state();
        chk("cnt0",   32'(bus0.fifo_counter),     32'(m0));
        chk("empty0", 32'(bus0.buf_empty),        32'(m0 == 0));
        chk("full0",  32'(bus0.buf_full),         32'(m0 == 16));
        chk("af0",    32'(bus0.buf_almost_full),  32'(m0 >= 14));
        chk("ae0",    32'(bus0.buf_almost_empty), 32'(m0 <= 2));
        chk("ovf0",   32'(bus0.overflow),         32'(ovf0));
        chk("unf0",   32'(bus0.underflow),        32'(unf0));
        chk("out0",   32'(bus0.buf_out),          32'(last0));
    endtask

    task automatic chk1_state();
        chk("cnt1",   32'(bus1.fifo_counter),     32'(m1));
        chk("empty1", 32'(bus1.buf_empty),        32'(m1 == 0));
        chk("full1",  32'(bus1.buf_full),         32'(m1 == 8));
        chk("af1",    32'(bus1.buf_almost_full),  32'(m1 >= 6));
        chk("ae1",    32'(bus1.buf_almost_empty), 32'(m1 <= 2));
        chk("ovf1",   32'(bus1.overflow),         32'(ovf1));
        chk("unf1",   32'(bus1.underflow),        32'(unf1));
        chk("out1",   32'(bus1.buf_out),          (m1 == 0) ? 32'h0 : 32'(sb1[0]));
    endtask

    task automatic cyc0(input logic wr, input logic rd, input logic [7:0] din);
        logic       racc, wacc;
        logic [7:0] exp_d;
        exp_d = 8'h00;
        racc  = rd && (m0 != 0);
        wacc  = wr && ((m0 != 16) || rd);
        if (wr && !wacc) ovf0 = 1'b1;
        if (rd && !racc) unf0 = 1'b1;
        if (racc) exp_d = sb0.pop_front();
        if (wacc) sb0.push_back(din);
        m0 = m0 + int'(wacc) - int'(racc);
        bus0.wr_en  = wr;
        bus0.rd_en  = rd;
        bus0.buf_in = din;
        @(posedge clk);
        #1;
        bus0.wr_en = 1'b0;
        bus0.rd_en = 1'b0;
        if (racc) begin
            chk("rd_data0", 32'(bus0.buf_out), 32'(exp_d));
            last0 = exp_d;
        end
        chk0_state();
    endtask

    task automatic cyc1(input logic wr, input logic rd, input logic [7:0] din);
        logic       racc, wacc;
        logic [7:0] popped;
        racc = rd && (m1 != 0);
        wacc = wr && ((m1 != 8) || rd);
        if (wr && !wacc) ovf1 = 1'b1;
        if (rd && !racc) unf1 = 1'b1;
        bus1.wr_en  = wr;
        bus1.rd_en  = rd;
        bus1.buf_in = din;
        if (racc) begin
            popped = sb1.pop_front();
            chk("fwft_head", 32'(bus1.buf_out), 32'(popped));
            chk("fwft_order", 32'(bus1.buf_out), 32'(next_seq));
            next_seq++;
        end
        if (wacc) sb1.push_back(din);
        m1 = m1 + int'(wacc) - int'(racc);
        @(posedge clk);
        #1;
        bus1.wr_en = 1'b0;
        bus1.rd_en = 1'b0;
        chk1_state();
    endtask

    task automatic do_reset(input logic wr);
        rst         = 1'b1;
        bus0.wr_en  = wr;
        bus0.buf_in = 8'hEE;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        bus0.wr_en = 1'b0;
        sb0.delete();
        sb1.delete();
        m0 = 0; m1 = 0;
        ovf0 = 1'b0; unf0 = 1'b0; ovf1 = 1'b0; unf1 = 1'b0;
        last0 = 8'h00;
        chk0_state();
        chk1_state();
    endtask

    initial begin
        rst = 1'b1;
        bus0.wr_en = 1'b0; bus0.rd_en = 1'b0; bus0.buf_in = 8'h00;
        bus1.wr_en = 1'b0; bus1.rd_en = 1'b0; bus1.buf_in = 8'h00;
        do_reset(1'b0);

        // fill, overflow attempt, drain, underflow
        for (int i = 0; i < 16; i++) cyc0(1'b1, 1'b0, 8'(i));
        cyc0(1'b1, 1'b0, 8'hFF);
        for (int i = 0; i < 16; i++) cyc0(1'b0, 1'b1, 8'h00);
        cyc0(1'b0, 1'b1, 8'h00);
        cyc0(1'b1, 1'b1, 8'hA5);
        cyc0(1'b0, 1'b1, 8'h00);

        // simultaneous write and read while full
        do_reset(1'b0);
        for (int i = 0; i < 16; i++) cyc0(1'b1, 1'b0, 8'(i));
        cyc0(1'b1, 1'b1, 8'h55);
        for (int i = 0; i < 16; i++) cyc0(1'b0, 1'b1, 8'h00);

        // FWFT streaming through pointer wrap
        next_seq = 1;
        cyc1(1'b1, 1'b0, 8'd1);
        for (int i = 2; i <= 20; i++) cyc1(1'b1, 1'b1, 8'(i));
        cyc1(1'b0, 1'b1, 8'h00);

        // reset mid-operation alongside a write
        for (int i = 0; i < 5; i++) cyc0(1'b1, 1'b0, 8'(8'h30 + i));
        do_reset(1'b1);
        cyc0(1'b0, 1'b1, 8'h00);
        cyc0(1'b1, 1'b0, 8'h77);
        cyc0(1'b0, 1'b1, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
